// File: rtl/dcache_nway.sv
// N-way set-associative data cache with round-robin replacement and a word-serial req/ack
// refill/eviction port. Write-back/write-allocate, or write-through/no-allocate when WTHRU=1.
module dcache_nway #(
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int WORDS = 4,
  parameter int WTHRU = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam bit WT    = (WTHRU != 0);

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_WTWR, S_RESP} state_t;

  state_t                       r_state;
  logic [OFF_W-1:0]             r_beat;
  logic [WAY_W-1:0]             r_victim;
  logic [SETS-1:0][WAYS-1:0]    r_valid;
  logic [SETS-1:0][WAYS-1:0]    r_dirty;
  logic [SETS-1:0][WAY_W-1:0]   r_rr;
  logic [TAG_W-1:0]             r_tag  [SETS][WAYS];
  logic [31:0]                  r_data [SETS][WAYS][WORDS];

  logic [OFF_W-1:0] w_word;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_unused;
  logic             w_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic [WAY_W-1:0] w_victim;
  logic [31:0]      w_hit_word;
  logic             w_in_acc;
  logic             w_store_wb;
  logic             w_fill_we;
  logic             w_wt_upd;
  logic             w_last;
  logic             w_dwe;
  logic [WAY_W-1:0] w_dway;
  logic [OFF_W-1:0] w_dword;
  logic [31:0]      w_dval;

  assign w_word   = cpu_addr[2 +: OFF_W];
  assign w_idx    = cpu_addr[2+OFF_W +: IDX_W];
  assign w_tag    = cpu_addr[31 -: TAG_W];
  assign w_unused = ^cpu_addr[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Scanning downward leaves the lowest-numbered invalid way as the final pick.
  always_comb begin
    w_victim = r_rr[w_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
    end
  end

  assign w_hit_word = r_data[w_idx][w_hit_way][w_word];
  assign w_in_acc   = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_store_wb = !WT && w_in_acc && cpu_req && cpu_we && w_hit;
  assign w_fill_we  = (r_state == S_FILL) && mem_ack;
  assign w_wt_upd   = (r_state == S_WTWR) && mem_ack && w_hit;
  assign w_last     = (r_beat == OFF_W'(WORDS - 1));

  always_comb begin
    w_dwe   = 1'b0;
    w_dway  = w_hit_way;
    w_dword = w_word;
    w_dval  = merge_bytes(w_hit_word, cpu_wdata, cpu_be);
    if (w_fill_we) begin
      w_dwe   = 1'b1;
      w_dway  = r_victim;
      w_dword = r_beat;
      w_dval  = mem_rdata;
    end else if (w_store_wb || w_wt_upd) begin
      w_dwe = 1'b1;
    end
  end

  // NOTE: data and tag arrays are not reset; the valid bits alone make their contents meaningful.
  always_ff @(posedge clk) begin
    if (w_dwe) r_data[w_idx][w_dway][w_dword] <= w_dval;
    if (w_fill_we && w_last) r_tag[w_idx][r_victim] <= w_tag;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_victim <= '0;
      r_valid  <= '0;
      r_dirty  <= '0;
      r_rr     <= '0;
    end else begin
      if (w_store_wb) r_dirty[w_idx][w_hit_way] <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            if (WT && cpu_we) begin
              r_state <= S_WTWR;
            end else if (!w_hit) begin
              r_victim <= w_victim;
              r_beat   <= '0;
              r_state  <= (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) ? S_WB : S_FILL;
            end
          end
        end
        S_WB: begin
          if (mem_ack) begin
            r_beat <= r_beat + OFF_W'(1);
            if (w_last) r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            r_beat <= r_beat + OFF_W'(1);
            if (w_last) begin
              r_valid[w_idx][r_victim] <= 1'b1;
              r_dirty[w_idx][r_victim] <= 1'b0;
              r_rr[w_idx] <= (r_rr[w_idx] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_idx] + WAY_W'(1);
              r_state     <= S_RESP;
            end
          end
        end
        S_WTWR:  if (mem_ack) r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory-port outputs decode straight from state, so an async reset drops mem_req at once.
  assign mem_req = (r_state == S_WB) || (r_state == S_FILL) || (r_state == S_WTWR);
  assign mem_we  = (r_state == S_WB) || (r_state == S_WTWR);

  always_comb begin
    mem_addr  = {w_tag, w_idx, r_beat, 2'b00};
    mem_wdata = cpu_wdata;
    mem_be    = 4'hF;
    case (r_state)
      S_WB: begin
        mem_addr  = {r_tag[w_idx][r_victim], w_idx, r_beat, 2'b00};
        mem_wdata = r_data[w_idx][r_victim][r_beat];
      end
      S_WTWR: begin
        mem_addr = {w_tag, w_idx, w_word, 2'b00};
        mem_be   = cpu_be;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_state)
      S_IDLE:  cpu_stall = cpu_req && (!w_hit || (WT && cpu_we));
      S_RESP:  cpu_stall = 1'b0;
      default: cpu_stall = 1'b1;
    endcase
  end

  assign cpu_rdata = (w_in_acc && cpu_req && w_hit) ? w_hit_word : 32'h0;

endmodule

// File: tb/tb_dcache_nway.sv
// Scoreboard bench for dcache_nway: a write-back and a write-through instance share one
// word-addressed memory model; expected beats and load data are queued by the stimulus.
module tb_dcache_nway;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [3:0]  cpu_be = '0;
  logic [31:0] cpu_wdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] a_rdata, b_rdata, a_maddr, b_maddr, a_mwdata, b_mwdata;
  logic        a_stall, b_stall, a_mreq, b_mreq, a_mwe, b_mwe;
  logic [3:0]  a_mbe, b_mbe;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, mem_req, mem_we;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  assign cpu_rdata = sel ? b_rdata  : a_rdata;
  assign cpu_stall = sel ? b_stall  : a_stall;
  assign mem_req   = sel ? b_mreq   : a_mreq;
  assign mem_we    = sel ? b_mwe    : a_mwe;
  assign mem_addr  = sel ? b_maddr  : a_maddr;
  assign mem_wdata = sel ? b_mwdata : a_mwdata;
  assign mem_be    = sel ? b_mbe    : a_mbe;

  dcache_nway #(.SETS(16), .WAYS(2), .WORDS(4), .WTHRU(0)) u_dut_wb (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req & ~sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(a_rdata), .cpu_stall(a_stall),
    .mem_req(a_mreq), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_be(a_mbe),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack & ~sel));

  dcache_nway #(.SETS(16), .WAYS(2), .WORDS(4), .WTHRU(1)) u_dut_wt (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req & sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(b_rdata), .cpu_stall(b_stall),
    .mem_req(b_mreq), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_be(b_mbe),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack & sel));

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_loads[$];
  logic [31:0] mem [1024];
  int n_tests = 0;
  int n_fail = 0;
  int beats_seen = 0;
  int ack_lat = 0;
  int wait_cnt = 0;
  logic        held_v = 1'b0;
  logic [31:0] held_addr, held_wdata;
  logic        held_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_rd(input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.we = 1'b0; b.addr = base + 32'(4 * i); b.wdata = '0; b.be = '0;
      exp_beats.push_back(b);
    end
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    beat_t b;
    b.we = 1'b1; b.addr = a; b.wdata = d; b.be = be;
    exp_beats.push_back(b);
  endtask

  // Called at posedge+1; holds the request until the negedge that shows no stall.
  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int exp_stall, input string name);
    int n;
    n = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
    @(negedge clk);
    while (cpu_stall && n < 300) begin
      n++;
      @(negedge clk);
    end
    check({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  // Memory responder: decides mem_ack for the coming edge, checks the request holds while waiting.
  always @(posedge clk) begin
    #2;
    if (!rst_n || !mem_req) begin
      mem_ack = 1'b0; wait_cnt = 0; held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_addr", mem_addr, held_addr);
        check("hold_we", 32'(mem_we), 32'(held_we));
        check("hold_wdata", mem_wdata, held_wdata);
        check("hold_stall", 32'(cpu_stall), 32'd1);
      end
      if (wait_cnt >= ack_lat) begin
        mem_ack = 1'b1; mem_rdata = mem[mem_addr[11:2]]; wait_cnt = 0; held_v = 1'b0;
      end else begin
        mem_ack = 1'b0; wait_cnt++; held_v = 1'b1;
        held_addr = mem_addr; held_we = mem_we; held_wdata = mem_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mem_req && mem_ack && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
  end

  // Monitor: pops the scoreboard whenever a beat is accepted or a load completes.
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_ack) begin : beat_mon
      beat_t e;
      beats_seen++;
      if (exp_beats.size() == 0) begin
        check("unexpected_beat", mem_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_beats.pop_front();
        check("beat_we", 32'(mem_we), 32'(e.we));
        check("beat_addr", mem_addr, e.addr);
        if (e.we) begin
          check("beat_wdata", mem_wdata, e.wdata);
          check("beat_be", 32'(mem_be), 32'(e.be));
        end
      end
    end
    if (rst_n && cpu_req && !cpu_stall && !cpu_we) begin
      if (exp_loads.size() == 0) check("unexpected_load", cpu_rdata, 32'hFFFF_FFFF);
      else check("load_data", cpu_rdata, exp_loads.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A5A_0000 | 32'(i * 4);
    #23;
    check("rst_stall", 32'(a_stall), 32'd0);
    check("rst_mem_req", 32'(a_mreq | b_mreq), 32'd0);
    check("rst_mem_we", 32'(a_mwe | b_mwe), 32'd0);
    check("rst_rdata", a_rdata | b_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss refills the line, then the next word hits with no stall.
    exp_rd(32'h100); exp_loads.push_back(32'h5A5A_0100);
    access(1'b0, 32'h100, 4'h0, 32'h0, 5, "t1_miss");
    exp_loads.push_back(32'h5A5A_0104);
    access(1'b0, 32'h104, 4'h0, 32'h0, 0, "t1_hit");

    // Partial store hit: no memory traffic, merged on reload.
    base = beats_seen;
    access(1'b1, 32'h104, 4'b0011, 32'hDEAD_BEEF, 0, "t2_store_hit");
    check("t2_no_beat", 32'(beats_seen), 32'(base));
    exp_loads.push_back(32'h5A5A_BEEF);
    access(1'b0, 32'h104, 4'h0, 32'h0, 0, "t2_reload");

    // Fill the second way, then evict the dirty way 0.
    exp_rd(32'h500); exp_loads.push_back(32'h5A5A_0500);
    access(1'b0, 32'h500, 4'h0, 32'h0, 5, "t3_fill_way1");
    exp_wr(32'h100, 32'h5A5A_0100, 4'hF); exp_wr(32'h104, 32'h5A5A_BEEF, 4'hF);
    exp_wr(32'h108, 32'h5A5A_0108, 4'hF); exp_wr(32'h10C, 32'h5A5A_010C, 4'hF);
    exp_rd(32'h900); exp_loads.push_back(32'h5A5A_0900);
    access(1'b0, 32'h900, 4'h0, 32'h0, 9, "t3_dirty_evict");

    // Slow memory: the written-back word comes back through a delayed refill.
    ack_lat = 5;
    exp_rd(32'h100); exp_loads.push_back(32'h5A5A_BEEF);
    access(1'b0, 32'h104, 4'h0, 32'h0, 25, "t4_slow_refill");
    ack_lat = 0;

    // Store miss allocates, merges in RESP, and is written back later.
    exp_rd(32'h300);
    access(1'b1, 32'h30C, 4'b1100, 32'hCAFE_0000, 5, "t4_store_miss");
    exp_loads.push_back(32'hCAFE_030C);
    access(1'b0, 32'h30C, 4'h0, 32'h0, 0, "t4_store_reload");
    exp_rd(32'h900); exp_loads.push_back(32'h5A5A_0900);
    access(1'b0, 32'h900, 4'h0, 32'h0, 5, "t4_refill_900");
    exp_wr(32'h300, 32'h5A5A_0300, 4'hF); exp_wr(32'h304, 32'h5A5A_0304, 4'hF);
    exp_wr(32'h308, 32'h5A5A_0308, 4'hF); exp_wr(32'h30C, 32'hCAFE_030C, 4'hF);
    exp_rd(32'hA00); exp_loads.push_back(32'h5A5A_0A00);
    access(1'b0, 32'hA00, 4'h0, 32'h0, 9, "t4_evict_merged");

    // Write-through instance: store miss is one beat, no allocation.
    sel = 1'b1;
    exp_wr(32'h200, 32'h1122_3344, 4'b0101);
    access(1'b1, 32'h200, 4'b0101, 32'h1122_3344, 2, "t5_wt_store_miss");
    exp_rd(32'h200); exp_loads.push_back(32'h5A22_0244);
    access(1'b0, 32'h200, 4'h0, 32'h0, 5, "t5_wt_load_miss");
    exp_wr(32'h204, 32'h0BAD_F00D, 4'hF);
    access(1'b1, 32'h204, 4'hF, 32'h0BAD_F00D, 2, "t5_wt_store_hit");
    exp_loads.push_back(32'h0BAD_F00D);
    access(1'b0, 32'h204, 4'h0, 32'h0, 0, "t5_wt_reload");
    sel = 1'b0;

    // Reset during the third refill beat aborts the burst.
    ack_lat = 2;
    exp_rd(32'h600);
    exp_beats.delete(exp_beats.size() - 1);
    exp_beats.delete(exp_beats.size() - 1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h600; cpu_be = 4'h0;
    n = 0;
    @(negedge clk);
    while (!(mem_req && mem_addr == 32'h608) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t6_reached_beat2", mem_addr, 32'h608);
    #2;
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    check("t6_abort_mem_req", 32'(mem_req), 32'd0);
    check("t6_abort_stall", 32'(cpu_stall), 32'd0);
    check("t6_abort_queue", 32'(exp_beats.size()), 32'd0);
    #20;
    rst_n = 1'b1;
    ack_lat = 0;
    @(posedge clk); #1;
    exp_rd(32'h600); exp_loads.push_back(32'h5A5A_0600);
    access(1'b0, 32'h600, 4'h0, 32'h0, 5, "t6_full_refill");

    repeat (3) @(posedge clk);
    check("end_beats_left", 32'(exp_beats.size()), 32'd0);
    check("end_loads_left", 32'(exp_loads.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
